wb_writer: RTL and testbench
============================

// Module: wb_writer
// PURPOSE
//  Writeback stage for the pipelined core: the write-side driver of the 3-port register file.
//  Accepts completed MEM-stage results over a valid/ready handshake into a DEPTH-entry FIFO,
//  formats load data, selects the result source and drives the registered we3/wa3/wd3 write port.
//  Also reports pending writes to the hazard unit so that decode stalls on a RAW hit.
// PARAMETERS
//  DEPTH  2  buffer entries (power of 2, >=2)
//  AW     5  register address width
//  DW     32 data width
// PORTS
//  clk        in  1   clock; all state updates on posedge
//  reset      in  1   asynchronous, active-low reset
//  in_valid   in  1   MEM-stage result valid
//  in_ready   out 1   buffer can accept (= !full)
//  in_rw      in  1   instruction writes rd
//  in_rd      in  AW  destination register
//  in_src     in  2   00 ALU, 01 load, 10 pc_plus4, 11 ALU
//  in_f3      in  3   load funct3
//  in_alu     in  DW  ALU result; [1:0] is the load byte address
//  in_rdata   in  DW  raw memory read word
//  in_pc4     in  DW  PC+4
//  wb_stall   in  1   hold the head entry (write port borrowed)
//  q_rs1      in  AW  hazard query, source 1
//  q_rs2      in  AW  hazard query, source 2
//  pend_hit   out 1   a buffered, unwritten entry has rw=1, rd!=0, rd==q_rs1|q_rs2
//  we3        out 1   regfile write enable
//  wa3        out AW  regfile write address
//  wd3        out DW  regfile write data
//  instret    out 64  retired-entry count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset==0): FIFO empty, pointers 0; we3=0, wa3=0, wd3=0, instret=0.
//    Reset mid-operation discards all buffered entries; no write is issued for them.
//  - Push: on posedge when in_valid && in_ready. The result is formatted at push time and
//    stored as {rw, rd, data}.
//  - Pop: on posedge when !empty && !wb_stall. Registers we3<=rw && rd!=0, wa3<=rd, wd3<=data.
//    Any cycle without a pop: we3<=0 and wa3/wd3 hold their values. we3 pulses one cycle per entry.
//  - Latency: accepted at edge E0 -> we3 visible after E1 (with no stall). The regfile commits
//    on the following negedge.
//  - Full: in_ready=0; a same-cycle pop does not reopen ready until the next cycle (no pass-through).
//  - Simultaneous push and pop when neither full nor empty: both occur; count unchanged.
//  - Order: strict FIFO; wb_stall never reorders or drops entries.
//  - Entries with rw=0 or rd=0 still pop (they count toward instret) but never raise we3.
//  - Load format (sel = in_alu[1:0]):
//      000 LB  sign-extended byte[sel]
//      001 LH  sign-extended half[in_alu[1]]  (in_alu[0] ignored)
//      010 LW  full word
//      100 LBU zero-extended byte
//      101 LHU zero-extended half
//      other   full word
//  - pend_hit: combinational over all valid entries, excluding the entry whose write is
//    already on we3. Queries with q_rs=0 never hit.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: instret is a 64-bit counter, +1 per pop, wraps 2^64-1 -> 0.
//  WB_RETIRE_CNT_EN undefined: no counter is built; instret is tied to 0.
// TESTING
//  1. Reset, then push {rw=1, rd=5, src=ALU, alu=0x1234}
//     -> in the next cycle we3=1, wa3=5, wd3=0x1234 for exactly one cycle.
//  2. Load, rdata=0x80FF7F01:
//     - f3=000, alu[1:0]=3 -> wd3=0xFFFFFF80
//     - f3=100, alu[1:0]=3 -> wd3=0x00000080
//     - f3=001, alu[1:0]=2 -> wd3=0xFFFF80FF
//     - f3=101, alu[1:0]=0 -> wd3=0x00007F01
//  3. Hold wb_stall=1 and push 3 entries -> only 2 are accepted, in_ready=0 on the third;
//     release the stall -> we3 pulses in push order, then the third entry is accepted.
//  4. Buffer entry {rw=1, rd=7}, q_rs1=7 -> pend_hit=1; q_rs2=0 alone -> pend_hit=0;
//     rd=0 with rw=1 -> no hit and we3 stays 0.
//  5. Drop reset low while 2 entries are buffered
//     -> immediately we3=0, in_ready=1; after release, no stale write ever appears.
//  6. With WB_RETIRE_CNT_EN: 5 pops, including rw=0 entries -> instret=5.
//     Without the macro -> instret=0.

Source files
------------

// File: rtl/wb_writer.sv
// wb_writer: writeback FIFO driving the regfile write port; optional WB_RETIRE_CNT_EN adds a 64-bit instret counter
module wb_writer #(
  parameter int DEPTH = 2,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_rw,
  input  logic [AW-1:0] in_rd,
  input  logic [1:0]    in_src,
  input  logic [2:0]    in_f3,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_rdata,
  input  logic [DW-1:0] in_pc4,
  input  logic          wb_stall,
  input  logic [AW-1:0] q_rs1,
  input  logic [AW-1:0] q_rs2,
  output logic          pend_hit,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic [63:0]   instret
);
  localparam int PW = $clog2(DEPTH);
  logic [AW+DW:0] mem_q [DEPTH];
  logic [PW:0] wp_q, wp_d, rp_q, rp_d, cnt;
  logic we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d, ld, fmt;
  logic [7:0] b;
  logic [15:0] h;
  logic full, empty, push, pop;
  logic [AW+DW:0] head;
  assign cnt = wp_q - rp_q;
  assign empty = cnt == '0;
  assign full = cnt[PW];
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = !empty && !wb_stall;
  assign head = mem_q[rp_q[PW-1:0]];
  assign b = in_rdata[{in_alu[1:0], 3'b000} +: 8];
  assign h = in_rdata[{in_alu[1], 4'b0000} +: 16];
  always_comb begin
    ld = in_f3 == 3'b000 ? {{(DW-8){b[7]}}, b} :
         in_f3 == 3'b001 ? {{(DW-16){h[15]}}, h} :
         in_f3 == 3'b100 ? {{(DW-8){1'b0}}, b} :
         in_f3 == 3'b101 ? {{(DW-16){1'b0}}, h} : in_rdata;
    fmt = in_src == 2'b01 ? ld : in_src == 2'b10 ? in_pc4 : in_alu;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    we3_d = pop && head[AW+DW] && head[AW+DW-1:DW] != '0;
    wa3_d = pop ? head[AW+DW-1:DW] : wa3_q;
    wd3_d = pop ? head[DW-1:0] : wd3_q;
  end
  // a popped entry has left the FIFO, so the write on we3 is excluded automatically
  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      logic [AW-1:0] rd;
      off = PW'(i) - rp_q[PW-1:0];
      rd = mem_q[i][AW+DW-1:DW];
      if ({1'b0, off} < cnt && mem_q[i][AW+DW] && rd != '0 && (rd == q_rs1 || rd == q_rs2))
        pend_hit = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q[PW-1:0]] <= {in_rw, in_rd, fmt};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      we3_q <= we3_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
    end
  assign we3 = we3_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] ret_q, ret_d;
  assign ret_d = pop ? ret_q + 64'd1 : ret_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ret_q <= '0;
    else ret_q <= ret_d;
  assign instret = ret_q;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed self-checking bench for wb_writer
module tb_wb_writer;
  logic clk = 0, reset = 0;
  logic in_valid = 0, in_ready, in_rw = 0, wb_stall = 0, pend_hit, we3;
  logic [4:0] in_rd = 0, q_rs1 = 0, q_rs2 = 0, wa3;
  logic [1:0] in_src = 0;
  logic [2:0] in_f3 = 0;
  logic [31:0] in_alu = 0, in_rdata = 0, in_pc4 = 0, wd3;
  logic [63:0] instret;
  int checks = 0, errors = 0;

  wb_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_rw(in_rw),
    .in_rd(in_rd), .in_src(in_src), .in_f3(in_f3), .in_alu(in_alu), .in_rdata(in_rdata),
    .in_pc4(in_pc4), .wb_stall(wb_stall), .q_rs1(q_rs1), .q_rs2(q_rs2), .pend_hit(pend_hit),
    .we3(we3), .wa3(wa3), .wd3(wd3), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                        input logic [2:0] f3, input logic [31:0] alu);
    in_rw = rw; in_rd = rd; in_src = src; in_f3 = f3; in_alu = alu;
  endtask

  task automatic push(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                      input logic [2:0] f3, input logic [31:0] alu);
    set_in(rw, rd, src, f3, alu);
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic pop_chk(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    step();
    chk({tag, "_we3"}, 64'(we3), 64'(w));
    chk({tag, "_wa3"}, 64'(wa3), 64'(a));
    chk({tag, "_wd3"}, 64'(wd3), 64'(d));
  endtask

  initial begin
    #2;
    chk("rst_we3", 64'(we3), 0);
    chk("rst_wa3", 64'(wa3), 0);
    chk("rst_wd3", 64'(wd3), 0);
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_instret", instret, 0);
    #5 reset = 1;
    step();
    // single ALU write, one-cycle pulse
    push(1, 5, 2'b00, 3'b000, 32'h1234);
    chk("lat_we3_early", 64'(we3), 0);
    pop_chk("alu", 1, 5, 32'h1234);
    step();
    chk("pulse_we3", 64'(we3), 0);
    chk("hold_wa3", 64'(wa3), 5);
    chk("hold_wd3", 64'(wd3), 32'h1234);
    // load formatting
    in_rdata = 32'h80FF7F01;
    push(1, 1, 2'b01, 3'b000, 32'h3); pop_chk("lb3", 1, 1, 32'hFFFFFF80);
    push(1, 2, 2'b01, 3'b100, 32'h3); pop_chk("lbu3", 1, 2, 32'h00000080);
    push(1, 3, 2'b01, 3'b001, 32'h2); pop_chk("lh2", 1, 3, 32'hFFFF80FF);
    push(1, 4, 2'b01, 3'b101, 32'h0); pop_chk("lhu0", 1, 4, 32'h00007F01);
    push(1, 6, 2'b01, 3'b001, 32'h3); pop_chk("lh3", 1, 6, 32'hFFFF80FF);
    push(1, 8, 2'b01, 3'b010, 32'h1); pop_chk("lw", 1, 8, 32'h80FF7F01);
    push(1, 9, 2'b01, 3'b111, 32'h1); pop_chk("lother", 1, 9, 32'h80FF7F01);
    push(1, 10, 2'b01, 3'b000, 32'h1); pop_chk("lb1", 1, 10, 32'h0000007F);
    in_pc4 = 32'h100;
    push(1, 11, 2'b10, 3'b000, 32'h55); pop_chk("pc4", 1, 11, 32'h100);
    push(1, 12, 2'b11, 3'b000, 32'hABC); pop_chk("src3", 1, 12, 32'hABC);
    step();
    // stall fills the buffer, then drains in order
    wb_stall = 1;
    push(1, 13, 2'b00, 3'b000, 32'hA);
    push(1, 14, 2'b00, 3'b000, 32'hB);
    set_in(1, 15, 2'b00, 3'b000, 32'hC);
    in_valid = 1;
    chk("full_ready", 64'(in_ready), 0);
    step();
    chk("full_ready_hold", 64'(in_ready), 0);
    chk("stall_we3", 64'(we3), 0);
    wb_stall = 0;
    step();
    chk("drainA_we3", 64'(we3), 1);
    chk("drainA_wa3", 64'(wa3), 13);
    chk("drainA_wd3", 64'(wd3), 32'hA);
    chk("reopen_ready", 64'(in_ready), 1);
    step();
    in_valid = 0;
    chk("drainB_wa3", 64'(wa3), 14);
    chk("drainB_wd3", 64'(wd3), 32'hB);
    pop_chk("drainC", 1, 15, 32'hC);
    step();
    chk("drain_idle", 64'(we3), 0);
    // hazard query
    wb_stall = 1;
    push(1, 7, 2'b00, 3'b000, 32'h77);
    q_rs1 = 7; q_rs2 = 0; #1;
    chk("hit_rs1", 64'(pend_hit), 1);
    q_rs1 = 0; #1;
    chk("nohit_zero", 64'(pend_hit), 0);
    q_rs2 = 7; #1;
    chk("hit_rs2", 64'(pend_hit), 1);
    wb_stall = 0;
    step();
    chk("hit_after_pop", 64'(pend_hit), 0);
    chk("pop7_we3", 64'(we3), 1);
    wb_stall = 1;
    push(1, 0, 2'b00, 3'b000, 32'h99);
    q_rs1 = 0; q_rs2 = 0; #1;
    chk("rd0_nohit", 64'(pend_hit), 0);
    push(0, 7, 2'b00, 3'b000, 32'h98);
    q_rs1 = 7; #1;
    chk("rw0_nohit", 64'(pend_hit), 0);
    wb_stall = 0;
    step();
    chk("rd0_we3", 64'(we3), 0);
    step();
    chk("rw0_we3", 64'(we3), 0);
    chk("rw0_wa3", 64'(wa3), 7);
    // async reset with two entries buffered
    wb_stall = 1;
    push(1, 20, 2'b00, 3'b000, 32'h20);
    push(1, 21, 2'b00, 3'b000, 32'h21);
    q_rs1 = 20; #1;
    chk("prereset_ready", 64'(in_ready), 0);
    chk("prereset_hit", 64'(pend_hit), 1);
    #1 reset = 0;
    #1;
    chk("async_we3", 64'(we3), 0);
    chk("async_ready", 64'(in_ready), 1);
    chk("async_hit", 64'(pend_hit), 0);
    chk("async_wa3", 64'(wa3), 0);
    chk("async_instret", instret, 0);
    step();
    reset = 1;
    wb_stall = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale_we3", 64'(we3), 0);
    end
    // retirement count over 5 pops including rw=0
    set_in(1, 3, 2'b00, 3'b000, 32'h1);
    in_valid = 1;
    step();
    in_rw = 0; step();
    in_rw = 1; step();
    in_rw = 0; step();
    in_rd = 0; in_rw = 1; step();
    in_valid = 0;
    step();
    step();
`ifdef WB_RETIRE_CNT_EN
    chk("instret5", instret, 5);
`else
    chk("instret_tied", instret, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
